irrigation_pump_scheduler: RTL and testbench

Round-robin scheduler that shares the single irrigation pump between `ZONES` valve-controlled zones. It takes per-zone watering requests from the moisture logic and grants one zone at a time. Each grant runs a fixed valve-open → pump-on → pump-off → valve-close sequence. It sits between the sensor/threshold registers and the valve/pump output drivers, and enforces settle times, a minimum on-time and tank-low protection.

---
 rtl/irrigation_pump_scheduler_if.sv | 23 ++
 rtl/irrigation_pump_scheduler.sv | 124 ++++++++++++
 tb/tb_irrigation_pump_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/irrigation_pump_scheduler_if.sv
// Zone request / valve-pump control bundle between the moisture logic and the pump scheduler.
// The master drives requests and tank status; the slave (scheduler) drives the outputs.
interface irrigation_pump_scheduler_if #(
  parameter int unsigned ZONES = 4
) ();
  logic [ZONES-1:0]         REQ;
  logic                     TANK_LOW;
  logic [ZONES-1:0]         VALVE;
  logic                     PUMP;
  logic                     BUSY;
  logic [$clog2(ZONES)-1:0] ZONE_ID;
  logic                     TIMEOUT;

  modport master (
    output REQ, TANK_LOW,
    input  VALVE, PUMP, BUSY, ZONE_ID, TIMEOUT
  );

  modport slave (
    input  REQ, TANK_LOW,
    output VALVE, PUMP, BUSY, ZONE_ID, TIMEOUT
  );
endinterface

// File: rtl/irrigation_pump_scheduler.sv
// Round-robin pump scheduler: one zone at a time through OPEN -> WATER -> CLOSE.
// Optional grant length limit enabled by defining IRR_MAX_ON_EN.
module irrigation_pump_scheduler #(
  parameter int unsigned ZONES  = 4,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned MIN_ON = 8,
  parameter int unsigned MAX_ON = 64
) (
  input  logic                         CLK,
  input  logic                         RESET,
  irrigation_pump_scheduler_if.slave   bus
);

  localparam int unsigned ZW   = $clog2(ZONES);
  localparam int unsigned CM1  = (SETTLE > MIN_ON) ? SETTLE : MIN_ON;
  localparam int unsigned CMAX = (CM1 > MAX_ON) ? CM1 : MAX_ON;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] MIN_END    = CW'(MIN_ON - 1);
`ifdef IRR_MAX_ON_EN
  localparam logic [CW-1:0] MAX_END    = CW'(MAX_ON - 1);
`endif

  typedef enum logic [1:0] {IDLE, OPEN, WATER, CLOSE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [ZW-1:0]   ptr, ptr_n;
  logic [ZW-1:0]   zone_n;
  logic [ZONES-1:0] valve_n;
  logic            timeout_n;

  logic            found;
  logic [ZW-1:0]   gidx;
  logic [ZW:0]     probe;

  // First requesting zone at or above the pointer, wrapping past ZONES-1.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    probe = '0;
    for (int unsigned off = 0; off < ZONES; off++) begin
      probe = {1'b0, ptr} + (ZW+1)'(off);
      if (probe >= (ZW+1)'(ZONES))
        probe = probe - (ZW+1)'(ZONES);
      if (!found && bus.REQ[probe[ZW-1:0]]) begin
        found = 1'b1;
        gidx  = probe[ZW-1:0];
      end
    end
  end

  // Counter holds cycles-in-state minus one, so in WATER cnt+1 is the WATER cycle index.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    zone_n    = bus.ZONE_ID;
    timeout_n = 1'b0;
    cnt_n     = (cnt == '1) ? cnt : cnt + 1'b1;
    valve_n   = '0;

    case (state)
      IDLE: begin
        if (!bus.TANK_LOW && found) begin
          state_n = OPEN;
          zone_n  = gidx;
          ptr_n   = (gidx == ZW'(ZONES - 1)) ? '0 : gidx + 1'b1;
        end
      end
      OPEN: begin
        if (bus.TANK_LOW)
          state_n = CLOSE;
        else if (cnt == SETTLE_END)
          state_n = WATER;
      end
      WATER: begin
        if (bus.TANK_LOW)
          state_n = CLOSE;
`ifdef IRR_MAX_ON_EN
        else if (cnt == MAX_END) begin
          state_n   = CLOSE;
          timeout_n = 1'b1;
        end
`endif
        else if (cnt >= MIN_END && !bus.REQ[bus.ZONE_ID])
          state_n = CLOSE;
      end
      CLOSE: begin
        if (cnt == SETTLE_END)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state || state == IDLE)
      cnt_n = '0;
    if (state_n != IDLE)
      valve_n[zone_n] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      bus.VALVE   <= '0;
      bus.PUMP    <= 1'b0;
      bus.BUSY    <= 1'b0;
      bus.ZONE_ID <= '0;
      bus.TIMEOUT <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
      bus.VALVE   <= valve_n;
      bus.PUMP    <= (state_n == WATER);
      bus.BUSY    <= (state_n != IDLE);
      bus.ZONE_ID <= zone_n;
      bus.TIMEOUT <= timeout_n;
    end
  end

endmodule

// File: tb/tb_irrigation_pump_scheduler.sv
// Directed bench for irrigation_pump_scheduler (ZONES=4, SETTLE=4, MIN_ON=8, MAX_ON=64).
// Cycle n below counts rising edges since the edge on which IDLE sampled the request.
module tb_irrigation_pump_scheduler;
  localparam int unsigned ZONES = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  irrigation_pump_scheduler_if #(.ZONES(ZONES)) bus ();

  irrigation_pump_scheduler #(
    .ZONES (ZONES),
    .SETTLE(4),
    .MIN_ON(8),
    .MAX_ON(64)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    logic [1:0]  z;
    int unsigned pump_cnt;
    int unsigned to_cnt;

    bus.REQ      = '0;
    bus.TANK_LOW = 1'b0;

    // Reset state, both while held and just after release.
    tick();
    tick();
    chk("rst_valve",   32'(bus.VALVE),   32'd0);
    chk("rst_pump",    32'(bus.PUMP),    32'd0);
    chk("rst_busy",    32'(bus.BUSY),    32'd0);
    chk("rst_zone",    32'(bus.ZONE_ID), 32'd0);
    chk("rst_timeout", 32'(bus.TIMEOUT), 32'd0);
    RESET = 1'b0;
    tick();
    chk("idle_busy",  32'(bus.BUSY),  32'd0);
    chk("idle_valve", 32'(bus.VALVE), 32'd0);

    // Single request: OPEN n=1..4, WATER n=5..24, CLOSE n=25..28, IDLE n=29.
    bus.REQ = 4'b0001;
    for (int n = 1; n <= 30; n++) begin
      tick();
      chk("sr_valve", 32'(bus.VALVE), (n <= 28) ? 32'd1 : 32'd0);
      chk("sr_pump",  32'(bus.PUMP),  (n >= 5 && n <= 24) ? 32'd1 : 32'd0);
      chk("sr_busy",  32'(bus.BUSY),  (n <= 28) ? 32'd1 : 32'd0);
      chk("sr_timeout", 32'(bus.TIMEOUT), 32'd0);
      if (n == 1) chk("sr_zone", 32'(bus.ZONE_ID), 32'd0);
      if (n == 24) bus.REQ = '0;
    end

    // Fairness: each zone drops its request once watering starts, re-raises it back in IDLE.
    do_reset();
    bus.REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      z = 2'(g % 4);
      for (int n = 1; n <= 17; n++) begin
        tick();
        chk("fair_onehot", 32'($countones(bus.VALVE) <= 1), 32'd1);
        if (n == 1) begin
          chk("fair_zone",  32'(bus.ZONE_ID), 32'(z));
          chk("fair_valve", 32'(bus.VALVE),   32'(4'b0001 << z));
        end
        if (n == 4)  chk("fair_pump_pre",  32'(bus.PUMP), 32'd0);
        if (n == 5)  chk("fair_pump_on",   32'(bus.PUMP), 32'd1);
        if (n == 12) chk("fair_pump_last", 32'(bus.PUMP), 32'd1);
        if (n == 13) chk("fair_pump_off",  32'(bus.PUMP), 32'd0);
        if (n == 4)  bus.REQ = 4'b1111 & ~(4'b0001 << z);
        if (n == 17) begin
          chk("fair_idle", 32'(bus.BUSY), 32'd0);
          bus.REQ = (g == 4) ? 4'b0000 : 4'b1111;
        end
      end
    end

    // Minimum on-time: one-cycle pulse on zone 2 still gets MIN_ON pump cycles.
    tick();
    bus.REQ = 4'b0100;
    tick();
    chk("min_zone", 32'(bus.ZONE_ID), 32'd2);
    bus.REQ  = '0;
    pump_cnt = 0;
    for (int n = 2; n <= 20; n++) begin
      tick();
      if (bus.PUMP) pump_cnt++;
    end
    chk("min_pump_cycles", 32'(pump_cnt), 32'd8);
    chk("min_done_busy",   32'(bus.BUSY), 32'd0);

    // Tank low on the 3rd WATER cycle (n=7); pointer is at 3 so zone 0 is granted.
    bus.REQ = 4'b0001;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) chk("tank_zone", 32'(bus.ZONE_ID), 32'd0);
      if (n == 7) begin
        chk("tank_pump_before", 32'(bus.PUMP), 32'd1);
        bus.TANK_LOW = 1'b1;
      end
      if (n >= 8 && n <= 11) begin
        chk("tank_pump_off",   32'(bus.PUMP),  32'd0);
        chk("tank_close_valve", 32'(bus.VALVE), 32'd1);
      end
      if (n == 8) bus.REQ = 4'b1111;
      if (n == 12) begin
        chk("tank_valve_closed", 32'(bus.VALVE), 32'd0);
        chk("tank_idle_busy",    32'(bus.BUSY),  32'd0);
      end
    end
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("tank_no_grant", 32'(bus.BUSY), 32'd0);
    end
    bus.TANK_LOW = 1'b0;
    tick();
    chk("tank_resume_busy", 32'(bus.BUSY),    32'd1);
    chk("tank_resume_zone", 32'(bus.ZONE_ID), 32'd1);

    // Asynchronous reset in the middle of a WATER cycle.
    for (int n = 2; n <= 6; n++) tick();
    chk("mid_pump_before", 32'(bus.PUMP), 32'd1);
    #3;
    RESET = 1'b1;
    #1;
    chk("async_valve", 32'(bus.VALVE),   32'd0);
    chk("async_pump",  32'(bus.PUMP),    32'd0);
    chk("async_busy",  32'(bus.BUSY),    32'd0);
    chk("async_zone",  32'(bus.ZONE_ID), 32'd0);
    #1;
    RESET = 1'b0;
    // Pointer was 2 before reset; zone 1 (not 3) proves the search restarts at 0.
    bus.REQ = 4'b1010;
    tick();
    chk("post_rst_zone",  32'(bus.ZONE_ID), 32'd1);
    chk("post_rst_valve", 32'(bus.VALVE),   32'd2);
    bus.REQ = '0;

`ifdef IRR_MAX_ON_EN
    // Held request is cut off after MAX_ON pump cycles; zone 1 goes next.
    do_reset();
    bus.REQ  = 4'b0011;
    pump_cnt = 0;
    to_cnt   = 0;
    for (int n = 1; n <= 74; n++) begin
      tick();
      if (bus.PUMP)    pump_cnt++;
      if (bus.TIMEOUT) to_cnt++;
      if (n == 69) chk("max_timeout_pulse", 32'(bus.TIMEOUT), 32'd1);
      if (n == 74) begin
        chk("max_next_zone", 32'(bus.ZONE_ID), 32'd1);
        chk("max_next_busy", 32'(bus.BUSY),    32'd1);
      end
    end
    chk("max_pump_cycles", 32'(pump_cnt), 32'd64);
    chk("max_timeout_cnt", 32'(to_cnt),   32'd1);
    bus.REQ = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
